jtag_user_bridge: RTL

// - Consumes the BSCANE2 USER-chain outputs (TCK, TDI, SEL, SHIFT, CAPTURE, UPDATE) in the clk_p domain.
// - Shifts a DR frame by oversampling TCK, and on Update-DR issues one register-bus read or write.
// - Returns read data and status to the host via TDO on the next Capture-DR.
// - Sits between the BSCANE2 primitive and the system register file; clk_p must be >= 8x TCK.

---
 rtl/jtag_user_bridge_pkg.sv | 23 ++
 rtl/jtag_user_bridge_if.sv | 22 ++
 rtl/jtag_user_bridge_sync_edge.sv | 29 ++
 rtl/jtag_user_bridge.sv | 136 +++++++++++++
 4 files changed

// File: rtl/jtag_user_bridge_pkg.sv
// rtl/jtag_user_bridge_pkg.sv - shared types and constants for the JTAG user-chain bridge
package jtag_bridge_pkg;

    typedef enum logic {IDLE, REQ} state_t;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;
    localparam int DR_W       = DEF_DATA_W + DEF_ADDR_W + 1;

    // status field bit positions in the low end of the captured DR
    localparam int ST_OVR = 0;
    localparam int ST_TMO = 1;
    localparam int ST_BSY = 2;

    // read-data value reported when the bus never acknowledges
    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    // DR frame width for an arbitrary address/data geometry: {wdata, addr, we}
    function automatic int dr_width(input int addr_w, input int data_w);
        return data_w + addr_w + 1;
    endfunction

endpackage

// File: rtl/jtag_user_bridge_if.sv
// rtl/jtag_user_bridge_if.sv - register-bus request/ack interface between bridge and register file
interface jtag_user_bridge_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/jtag_user_bridge_sync_edge.sv
// rtl/jtag_user_bridge_sync_edge.sv - multi-flop synchroniser with rise/fall detection for one JTAG input
module jtag_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_p,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              q_d;

    // shift the async input through the chain and keep one extra sample for edge detection
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
endmodule

// File: rtl/jtag_user_bridge.sv
// rtl/jtag_user_bridge.sv - BSCANE2 user-chain to register-bus bridge, oversampling TCK in clk_p
module jtag_user_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk_p,
    input  logic                rst,
    input  logic                jtag_tck,
    input  logic                jtag_tdi,
    input  logic                jtag_sel,
    input  logic                jtag_shift,
    input  logic                jtag_capture,
    input  logic                jtag_update,
    output logic                jtag_tdo,
    output logic                o_busy,
    jtag_user_bridge_if.master  bus
);
    localparam int FW = dr_width(ADDR_W, DATA_W);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic s_tck, s_tdi, s_sel, s_shift, s_cap, s_upd;
    logic tck_rise, tck_fall;
    logic tdi_rise, tdi_fall, sel_rise, sel_fall, sh_rise, sh_fall;
    logic cap_rise, cap_fall, upd_rise, upd_fall;

    jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_tck (.clk_p(clk_p), .rst(rst), .d(jtag_tck),     .q(s_tck),   .rise(tck_rise), .fall(tck_fall));
    jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_tdi (.clk_p(clk_p), .rst(rst), .d(jtag_tdi),     .q(s_tdi),   .rise(tdi_rise), .fall(tdi_fall));
    jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sel (.clk_p(clk_p), .rst(rst), .d(jtag_sel),     .q(s_sel),   .rise(sel_rise), .fall(sel_fall));
    jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sh  (.clk_p(clk_p), .rst(rst), .d(jtag_shift),   .q(s_shift), .rise(sh_rise),  .fall(sh_fall));
    jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cap (.clk_p(clk_p), .rst(rst), .d(jtag_capture), .q(s_cap),   .rise(cap_rise), .fall(cap_fall));
    jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_upd (.clk_p(clk_p), .rst(rst), .d(jtag_update),  .q(s_upd),   .rise(upd_rise), .fall(upd_fall));

    logic [FW-1:0]     sr;
    logic [DATA_W-1:0] last_rdata;
    logic              ovr, tmo;
    logic              upd_lvl_d;
    logic [CW-1:0]     cnt;
    state_t            state;
    logic [ADDR_W:0]   status;

    // capture takes priority over shift when both are asserted
    wire cap_ev   = tck_rise & s_sel & s_cap;
    wire shift_ev = tck_rise & s_sel & s_shift & ~s_cap;
    wire upd_lvl  = s_sel & s_upd;
    wire upd      = upd_lvl & ~upd_lvl_d;
    wire ovr_set  = upd & (state != IDLE);
    wire tmo_hit  = (state == REQ) & ~bus.bus_ack & (cnt == CW'(TIMEOUT - 1));

    // status word placed under last_rdata in the captured frame
    always_comb begin
        status         = '0;
        status[ST_OVR] = ovr;
        status[ST_TMO] = tmo;
        status[ST_BSY] = o_busy;
    end

    // DR shift register and TDO; TDO changes only on TCK fall so the host samples a settled bit
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            jtag_tdo <= 1'b0;
        end else begin
            if (cap_ev)
                sr <= {last_rdata, status};
            else if (shift_ev)
                sr <= {s_tdi, sr[FW-1:1]};
            if (tck_fall)
                jtag_tdo <= sr[0];
        end
    end

    // sticky read-to-clear flags; a new set in the clearing cycle survives
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
            tmo <= 1'b0;
        end else begin
            ovr <= ovr_set | (ovr & ~cap_ev);
            tmo <= tmo_hit | (tmo & ~cap_ev);
        end
    end

    // request FSM with registered bus outputs, timeout counter and read-data latch
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            o_busy        <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            last_rdata    <= '0;
            cnt           <= '0;
            upd_lvl_d     <= 1'b0;
        end else begin
            upd_lvl_d <= upd_lvl;
            case (state)
                IDLE: begin
                    if (upd) begin
                        bus.bus_we    <= sr[0];
                        bus.bus_addr  <= sr[ADDR_W:1];
                        bus.bus_wdata <= sr[FW-1:ADDR_W+1];
                        bus.bus_req   <= 1'b1;
                        cnt           <= '0;
                        o_busy        <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we)
                            last_rdata <= bus.bus_rdata;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (tmo_hit) begin
                        bus.bus_req <= 1'b0;
                        last_rdata  <= DATA_W'(DEAD_BEEF);
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
